// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver peripheral: register map,
// STATUS/CTRL bit positions and the receive FSM state encoding.
package uart_pkg;

  // Register select values, taken from address bits [3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;
  localparam int ST_COUNT_LSB  = 8;

  // CTRL bit positions
  localparam int CTRL_CLR_ERR = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // Receive FSM states
  //   state      | meaning
  //   RX_IDLE    | line idle, waiting for a falling edge
  //   RX_START   | half a bit period in, confirm start bit is still low
  //   RX_DATA    | sampling 8 data bits, LSB first
  //   RX_PARITY  | sampling the even-parity bit (parity builds only)
  //   RX_STOP    | sampling the stop bit, then push or flag frame error
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; flush wins
// over everything else in its cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_dbus.sv
// UART receiver with a small data-bus register interface and byte FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_dbus
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int RISCV_WL   = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                uart_rx,
  input  logic                dbus_cmd_valid,
  input  logic                dbus_cmd_payload_wr,
  input  logic [3:0]          dbus_cmd_payload_address,
  input  logic [RISCV_WL-1:0] dbus_cmd_payload_data,
  output logic                dbus_rsp_ready,
  output logic [RISCV_WL-1:0] dbus_rsp_data,
  output logic                rx_irq
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            rx_fall;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic            ferr_evt_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
  logic            perr_evt_q;
  logic            parity_err_q;
`endif

  logic            overrun_q, frame_err_q, irq_en_q;
  logic            rsp_ready_q;
  logic [RISCV_WL-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]      reg_sel;
  logic            rd_req, wr_req, ctrl_wr;
  logic            clr_err, fifo_flush, fifo_pop, ovf_evt;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [FCW-1:0]  fifo_count;
  logic            unused_bits;

  assign reg_sel    = dbus_cmd_payload_address[3:2];
  assign rd_req     = dbus_cmd_valid & ~dbus_cmd_payload_wr;
  assign wr_req     = dbus_cmd_valid & dbus_cmd_payload_wr;
  assign ctrl_wr    = wr_req & (reg_sel == REG_CTRL);
  assign clr_err    = ctrl_wr & dbus_cmd_payload_data[CTRL_CLR_ERR];
  assign fifo_flush = ctrl_wr & dbus_cmd_payload_data[CTRL_FLUSH];
  assign fifo_pop   = rd_req & (reg_sel == REG_DATA) & ~fifo_empty;
  assign ovf_evt    = push_q & fifo_full & ~fifo_pop & ~fifo_flush;
  assign rx_fall    = rx_prev_q & ~rx_s2_q;
  assign unused_bits = ^{dbus_cmd_payload_address[1:0], dbus_cmd_payload_data};

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive FSM; bit timing from a down-counter that samples at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_evt_q <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_evt_q <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            state_q <= RX_START;
            cnt_q   <= CNT_HALF;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              state_q <= RX_IDLE;
            end else begin
              state_q   <= RX_DATA;
              cnt_q     <= CNT_FULL;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q   <= {rx_s2_q, shift_q[7:1]};
            cnt_q     <= CNT_FULL;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt_q == '0) begin
            par_bad_q <= ^{shift_q, rx_s2_q};
            cnt_q     <= CNT_FULL;
            state_q   <= RX_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (cnt_q == '0) begin
            state_q <= RX_IDLE;
            if (!rx_s2_q) begin
              ferr_evt_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_evt_q <= 1'b1;
`endif
            end else begin
              push_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_q),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .din    (shift_q),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Sticky error flags and interrupt enable; a new error wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      irq_en_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q    <= (overrun_q & ~clr_err) | ovf_evt;
      frame_err_q  <= (frame_err_q & ~clr_err) | ferr_evt_q;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= (parity_err_q & ~clr_err) | perr_evt_q;
`endif
      if (ctrl_wr) irq_en_q <= dbus_cmd_payload_data[CTRL_IRQ_EN];
    end
  end

  // Read data mux for the addressed register
  always_comb begin
    rsp_data_d = '0;
    case (reg_sel)
      REG_DATA: begin
        if (!fifo_empty) begin
          rsp_data_d[8]   = 1'b1;
          rsp_data_d[7:0] = fifo_dout;
        end
      end
      REG_STATUS: begin
        rsp_data_d[ST_NOT_EMPTY] = ~fifo_empty;
        rsp_data_d[ST_FULL]      = fifo_full;
        rsp_data_d[ST_OVERRUN]   = overrun_q;
        rsp_data_d[ST_FRAME_ERR] = frame_err_q;
`ifdef UART_RX_PARITY_EN
        rsp_data_d[ST_PARITY_ERR] = parity_err_q;
`endif
        rsp_data_d[ST_COUNT_LSB +: FCW] = fifo_count;
      end
      REG_CTRL:  rsp_data_d[CTRL_IRQ_EN] = irq_en_q;
      REG_RSVD:  rsp_data_d = '0;
      default:   rsp_data_d = '0;
    endcase
  end

  // Registered read response, one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_ready_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_ready_q <= rd_req;
      if (rd_req) rsp_data_q <= rsp_data_d;
    end
  end

  assign dbus_rsp_ready = rsp_ready_q;
  assign dbus_rsp_data  = rsp_data_q;
  assign rx_irq = irq_en_q & (~fifo_empty | overrun_q | frame_err_q
`ifdef UART_RX_PARITY_EN
                              | parity_err_q
`endif
                              );

endmodule

// File: tb/tb_uart_rx_dbus.sv
// Directed self-checking bench for uart_rx_dbus (default build, no parity).
module tb_uart_rx_dbus;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rx_irq;

  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_dbus #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (8),
    .RISCV_WL   (32)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .uart_rx                  (uart_rx),
    .dbus_cmd_valid           (cmd_valid),
    .dbus_cmd_payload_wr      (cmd_wr),
    .dbus_cmd_payload_address (cmd_addr),
    .dbus_cmd_payload_data    (cmd_data),
    .dbus_rsp_ready           (rsp_ready),
    .dbus_rsp_data            (rsp_data),
    .rx_irq                   (rx_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic rdy);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_data = 32'h0;
    tick(1);
    cmd_valid = 1'b0;
    d = rsp_data;
    rdy = rsp_ready;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd, output logic rdy);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_data = wd;
    tick(1);
    cmd_valid = 1'b0; cmd_wr = 1'b0;
    rdy = rsp_ready;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop;
    tick(DIV);
    uart_rx = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [31:0] d;
    logic        r;
    logic [7:0]  mid;

    // Reset state
    resetn = 1'b0;
    tick(3);
    check("reset_rsp_ready", {31'b0, rsp_ready}, 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rx_irq", {31'b0, rx_irq}, 32'h0);
    resetn = 1'b1;
    tick(2);
    bus_read(4'h4, d, r);
    check("reset_status", d, 32'h0);
    check("read_rsp_ready", {31'b0, r}, 32'h1);
    tick(1);
    check("rsp_ready_one_cycle", {31'b0, rsp_ready}, 32'h0);
    bus_read(4'h8, d, r);
    check("reset_ctrl", d, 32'h0);

    // Reserved offset and write response
    bus_write(4'hC, 32'hFFFF_FFFF, r);
    check("write_no_rsp", {31'b0, r}, 32'h0);
    bus_read(4'hC, d, r);
    check("rsvd_read", d, 32'h0);
    bus_read(4'h8, d, r);
    check("rsvd_write_ignored", d, 32'h0);

    // Single frame
    send_frame(8'hA5, 1'b1);
    bus_read(4'h4, d, r);
    check("a5_status", d, 32'h0000_0101);
    bus_read(4'h0, d, r);
    check("a5_data", d, 32'h0000_01A5);
    bus_read(4'h0, d, r);
    check("empty_data", d, 32'h0000_0000);

    // Overrun: nine frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    bus_read(4'h4, d, r);
    check("ovr_status", d, 32'h0000_0807);
    for (int i = 0; i < 8; i++) begin
      bus_read(4'h0, d, r);
      check("ovr_data", d, 32'h100 + 32'(i));
    end
    bus_read(4'h4, d, r);
    check("ovr_sticky", d, 32'h0000_0004);
    check("irq_disabled", {31'b0, rx_irq}, 32'h0);
    bus_write(4'h8, 32'h1, r);
    bus_read(4'h4, d, r);
    check("ovr_cleared", d, 32'h0);

    // Frame error
    send_frame(8'h3C, 1'b0);
    bus_read(4'h4, d, r);
    check("ferr_status", d, 32'h0000_0008);
    bus_write(4'h8, 32'h1, r);
    bus_read(4'h4, d, r);
    check("ferr_cleared", d, 32'h0);

    // Short glitch on the line
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(3 * DIV);
    bus_read(4'h4, d, r);
    check("glitch_status", d, 32'h0);

    // Flush
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_read(4'h4, d, r);
    check("pre_flush_status", d, 32'h0000_0201);
    bus_write(4'h8, 32'h2, r);
    bus_read(4'h4, d, r);
    check("flush_status", d, 32'h0);
    bus_read(4'h0, d, r);
    check("flush_data", d, 32'h0);

    // Interrupt
    bus_write(4'h8, 32'h4, r);
    bus_read(4'h8, d, r);
    check("ctrl_irq_en", d, 32'h4);
    check("irq_idle", {31'b0, rx_irq}, 32'h0);
    send_frame(8'h5A, 1'b1);
    check("irq_set", {31'b0, rx_irq}, 32'h1);
    bus_read(4'h0, d, r);
    check("irq_data", d, 32'h0000_015A);
    check("irq_dropped", {31'b0, rx_irq}, 32'h0);

    // Reset in the middle of data bit 4 of frame 0xF0
    mid = 8'hF0;
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      uart_rx = mid[i];
      tick(DIV);
    end
    uart_rx = mid[4];
    tick(5);
    resetn = 1'b0;
    tick(2);
    check("midrst_rsp_ready", {31'b0, rsp_ready}, 32'h0);
    check("midrst_irq", {31'b0, rx_irq}, 32'h0);
    resetn = 1'b1;
    tick(3);
    for (int i = 5; i < 8; i++) begin
      uart_rx = mid[i];
      tick(DIV);
    end
    uart_rx = 1'b1;
    tick(DIV + 4);
    bus_read(4'h4, d, r);
    check("midrst_status", d, 32'h0);
    bus_read(4'h8, d, r);
    check("midrst_ctrl", d, 32'h0);
    send_frame(8'h55, 1'b1);
    bus_read(4'h0, d, r);
    check("post_rst_data", d, 32'h0000_0155);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_dbus.md
UART_RX_DBUS -- requirements
Module: uart_rx_dbus

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive byte FIFO depth (power of 2, at least 2).
REQ-004 SHALL have parameter RISCV_WL, default 32, data bus width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port dbus_cmd_valid, input, 1, bus access strobe for this peripheral.
REQ-009 SHALL have port dbus_cmd_payload_wr, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port dbus_cmd_payload_address, input, 4, byte offset; bits [3:2] select the register.
REQ-011 SHALL have port dbus_cmd_payload_data, input, RISCV_WL, write data.
REQ-012 SHALL have port dbus_rsp_ready, output, 1, read response valid.
REQ-013 SHALL have port dbus_rsp_data, output, RISCV_WL, read data.
REQ-014 SHALL have port rx_irq, output, 1, level interrupt.

Function
REQ-015 SHALL always be ready for commands (no back-pressure); dbus_rsp_ready SHALL assert exactly 1 cycle after a valid read and SHALL stay low for writes.
REQ-016 SHALL map registers at offset 0x0 DATA (RO), 0x4 STATUS (RO) and 0x8 CTRL (RW); offset 0xC SHALL read 0 and ignore writes.
REQ-017 SHALL return {23'b0, valid, byte} on a DATA read; an empty FIFO SHALL return valid=0 with byte 0, and a non-empty FIFO SHALL pop one entry.
REQ-018 SHALL lay out STATUS as bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bit4 parity_err (sticky), and [15:8] FIFO count.
REQ-019 SHALL decode CTRL writes as bit0 clear all sticky errors (self-clearing), bit1 flush FIFO (self-clearing) and bit2 irq_en; a CTRL read SHALL return {29'b0, irq_en, 2'b0}.
REQ-020 SHALL drive rx_irq = irq_en & (not_empty | overrun | frame_err | parity_err).
REQ-021 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-022 SHALL use bit period DIV = CLK_FREQ/BAUD_RATE (integer), with a counter width of $clog2(DIV).
REQ-023 SHALL implement FSM IDLE->START->DATA->(PARITY)->STOP->IDLE.
REQ-024 IDLE: on a synchronized falling edge, SHALL go to START.
REQ-025 START: after DIV/2 clocks, SHALL sample the line; a 1 means glitch -> IDLE, no error.
REQ-026 DATA: SHALL take 8 samples at DIV-clock spacing, LSB first.
REQ-027 STOP: SHALL sample after DIV clocks; 1 pushes the byte, 0 sets frame_err and discards the byte; the FSM then returns to IDLE at the sample.
REQ-028 SHALL drop the byte when pushing into a full FIFO, set overrun and leave the contents unchanged.
REQ-029 SHALL perform both a simultaneous push and pop in the same cycle, leaving count unchanged; this includes the full case, which SHALL NOT raise overrun.
REQ-030 SHALL give flush priority over a same-cycle push, and the pushed byte SHALL be lost.

Reset
REQ-031 SHALL, while resetn=0 at a clock edge, set FSM to IDLE, FIFO empty, sticky errors 0, irq_en 0, dbus_rsp_ready 0, dbus_rsp_data 0, rx_irq 0 and synchronizer flops 1.
REQ-032 SHALL abandon a frame in progress when reset is applied mid-frame; after release the FSM SHALL wait for the next falling edge.

Configuration
REQ-033 With UART_RX_PARITY_EN defined, SHALL include the PARITY state between DATA and STOP, check even parity, set parity_err on mismatch and discard the byte.
REQ-034 Without UART_RX_PARITY_EN, SHALL omit the PARITY state, and STATUS bit4 SHALL read 0.

Structure
REQ-035 SHALL take register offsets, STATUS/CTRL bit indices and the FSM state enum from shared package uart_pkg.
REQ-036 SHALL instantiate the FIFO as sub-module sync_fifo (parameters WIDTH and DEPTH; push, pop, flush, full, empty and count ports).

Verification
REQ-037 SHALL verify that, with CLK_FREQ=1000000 and BAUD_RATE=100000, frame 0xA5 followed by a DATA read returns 0x1A5, and a second read returns 0x000.
REQ-038 SHALL verify that 9 frames 0x00..0x08 into FIFO_DEPTH=8 give STATUS full=1, overrun=1 and count=8, and that 8 reads return 0x00..0x07.
REQ-039 SHALL verify that a stop bit of 0 on frame 0x3C gives frame_err=1 and count=0, and that a CTRL write of 0x1 clears it.
REQ-040 SHALL verify that a 3-clock low glitch produces no FSM advance past START, no push and no error.
REQ-041 SHALL verify that irq_en=1 and one frame received gives rx_irq=1, and that the DATA read drops it the following cycle.
REQ-042 SHALL verify that resetn=0 during DATA bit 4 leaves FIFO empty, and that the next clean frame 0x55 is received correctly.
